// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light timing back-end.
package f1_pkg;

    // Default prescaler width (cycles per base tick).
    localparam int DEF_TICK_W = 16;

    // Width of the random generator and of the delay counter fed from it.
    localparam int LFSR_BITS = 7;

    // Non-zero seed; an all-zero LFSR would never leave zero.
    localparam logic [LFSR_BITS-1:0] LFSR_SEED = 7'b000_0001;

    // Feedback taps giving a maximal-length (127-state) sequence.
    localparam int LFSR_TAP_HI = 6;
    localparam int LFSR_TAP_LO = 5;

    // Delay FSM: waiting for a start edge, or counting down a random delay.
    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } delay_state_e;

    // One LFSR step: shift left, feed back the XOR of the two taps.
    function automatic logic [LFSR_BITS-1:0] lfsr_next(input logic [LFSR_BITS-1:0] cur);
        return {cur[LFSR_BITS-2:0], cur[LFSR_TAP_HI] ^ cur[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/f1_lfsr7.sv
// Free-running 7-bit maximal-length LFSR. Advances on every clock edge and
// is reusable by any block that needs a cheap pseudo-random value.
module f1_lfsr7
    import f1_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    output logic [LFSR_BITS-1:0] value
);

    // Shift register: seeded on reset, then steps every cycle unconditionally.
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= LFSR_SEED;
        end else begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/f1_light_timer.sv
// Timing back-end for the F1 start-light sequencer.
// - A shared prescaler turns clk into base ticks of tick_period cycles.
// - While cmd_seq is high, each tick becomes an en_out step pulse.
// - A rising edge on cmd_delay captures the current LFSR value D and, D ticks
//   later, time_out pulses once ("lights out").
module f1_light_timer
    import f1_pkg::*;
#(
    parameter int TICK_W = DEF_TICK_W,
    parameter int LFSR_W = LFSR_BITS   // fixed by the LFSR taps; keep at 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TICK_W-1:0] tick_period,
    input  logic              cmd_seq,
    input  logic              cmd_delay,
    output logic              en_out,
    output logic              time_out,
    output logic              busy,
    output logic [LFSR_W-1:0] delay_value
);

    // ------------------------------------------------------------------
    // Random source
    // ------------------------------------------------------------------
    logic [LFSR_W-1:0] lfsr_value;

    f1_lfsr7 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr_value)
    );

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    // pre_live says pre_cnt holds a count in flight. When it is clear the
    // prescaler is "held at P-1": the reload value is taken straight from
    // tick_period, so the reset value needs no dependency on an input.
    delay_state_e      state_q;
    delay_state_e      state_d;
    logic [TICK_W-1:0] period_m1;
    logic [TICK_W-1:0] pre_cnt;
    logic [TICK_W-1:0] pre_cur;
    logic              pre_live;
    logic              run;
    logic              tick;

    // Reload value P-1, with a programmed period of 0 behaving as 1.
    always_comb begin
        if (tick_period == '0) begin
            period_m1 = '0;
        end else begin
            period_m1 = tick_period - TICK_W'(1);
        end
    end

    // The prescaler is shared between step pulses and the delay countdown.
    assign run     = cmd_seq | (state_q == COUNT);
    assign pre_cur = pre_live ? pre_cnt : period_m1;
    assign tick    = run & (pre_cur == '0);

    // Prescaler count: held while idle, counts down and reloads on each tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt  <= '0;
            pre_live <= 1'b0;
        end else if (!run) begin
            pre_live <= 1'b0;
        end else begin
            pre_live <= 1'b1;
            if (tick) begin
                pre_cnt <= period_m1;
            end else begin
                pre_cnt <= pre_cur - TICK_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Step pulses and start-edge detection
    // ------------------------------------------------------------------
    logic cmd_delay_q;
    logic start;

    assign start = cmd_delay & ~cmd_delay_q;

    // en_out follows the tick only while cmd_seq is still requested, so a
    // dropped cmd_seq never emits a late pulse; cmd_delay is delayed for edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_out      <= 1'b0;
            cmd_delay_q <= 1'b0;
        end else begin
            en_out      <= tick & cmd_seq;
            cmd_delay_q <= cmd_delay;
        end
    end

    // ------------------------------------------------------------------
    // Delay FSM
    // ------------------------------------------------------------------
    logic [LFSR_W-1:0] delay_cnt;
    logic [LFSR_W-1:0] delay_cnt_d;
    logic [LFSR_W-1:0] delay_value_d;
    logic              time_out_d;

    // Next state: capture D on a start edge in IDLE, count ticks down in
    // COUNT, and fire time_out on the tick that consumes the last one.
    // NOTE: every variable gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        delay_cnt_d   = delay_cnt;
        delay_value_d = delay_value;
        time_out_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    delay_cnt_d   = lfsr_value;
                    delay_value_d = lfsr_value;
                    state_d       = COUNT;
                end
            end
            COUNT: begin
                // Start edges are deliberately ignored here: no restart.
                if (tick) begin
                    if (delay_cnt == LFSR_W'(1)) begin
                        time_out_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        delay_cnt_d = delay_cnt - LFSR_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and its registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            delay_cnt   <= '0;
            delay_value <= '0;
            time_out    <= 1'b0;
        end else begin
            state_q     <= state_d;
            delay_cnt   <= delay_cnt_d;
            delay_value <= delay_value_d;
            time_out    <= time_out_d;
        end
    end

    assign busy = (state_q == COUNT);

endmodule

// File: tb/tb_f1_light_timer.sv
// Self-checking bench for f1_light_timer: directed scenarios with fixed
// expected cycle numbers, then a randomized run against a behavioural model.
module tb_f1_light_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] tick_period;
    logic        cmd_seq;
    logic        cmd_delay;
    logic        en_out;
    logic        time_out;
    logic        busy;
    logic [6:0]  delay_value;

    always #5 clk = ~clk;

    f1_light_timer dut (
        .clk         (clk),
        .rst         (rst),
        .tick_period (tick_period),
        .cmd_seq     (cmd_seq),
        .cmd_delay   (cmd_delay),
        .en_out      (en_out),
        .time_out    (time_out),
        .busy        (busy),
        .delay_value (delay_value)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    // seq[n] is the random value seen by the n-th clock edge after reset.
    int seq[127];
    bit m_busy, m_en, m_to, m_held, m_dq;
    int m_per, m_pos, m_left, m_dv, m_idx, edge_no;

    task automatic build_seq();
        int v;
        v = 1;
        for (int i = 0; i < 127; i++) begin
            seq[i] = v;
            v = ((v << 1) & 127) | (((v >> 6) ^ (v >> 5)) & 1);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_en = 0; m_to = 0; m_held = 1; m_dq = 0;
        m_per = 1; m_pos = 0; m_left = 0; m_dv = 0; m_idx = 0; edge_no = 0;
    endtask

    // One clock edge: base ticks every m_per running cycles, a delay of D
    // ticks after a rising cmd_delay while idle.
    task automatic model_edge();
        bit run, tck, start;
        int eff;
        eff = (tick_period == 0) ? 1 : int'(tick_period);
        run = cmd_seq || m_busy;
        tck = 0;
        if (!run) begin
            m_held = 1;
        end else begin
            if (m_held) begin
                m_per = eff; m_pos = 0; m_held = 0;
            end
            if (m_pos == m_per - 1) begin
                tck = 1; m_pos = 0; m_per = eff;
            end else begin
                m_pos++;
            end
        end
        start = cmd_delay && !m_dq;
        m_dq  = cmd_delay;
        m_en  = tck && cmd_seq;
        m_to  = 0;
        if (m_busy) begin
            if (tck) begin
                m_left--;
                if (m_left == 0) begin
                    m_to = 1; m_busy = 0;
                end
            end
        end else if (start) begin
            m_left = seq[m_idx]; m_dv = seq[m_idx]; m_busy = 1;
        end
        m_idx = (m_idx + 1) % 127;
        edge_no++;
    endtask

    // Advance one cycle and compare all outputs 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("en_out", en_out, m_en);
        check("time_out", time_out, m_to);
        check("busy", busy, m_busy);
        check("delay_value", delay_value, m_dv);
    endtask

    // Called 1 ns after an edge: asserts rst mid-cycle, checks the async
    // clear, releases it away from the next edge.
    task automatic apply_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_en_out", en_out, 0);
        check("rst_time_out", time_out, 0);
        check("rst_busy", busy, 0);
        check("rst_delay_value", delay_value, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int to_edge, to_cnt, en_cnt, dv_cap;
        bit to_with_en;
        int en_q[$];
        int lfsr_exp[4];

        build_seq();
        model_reset();
        rst = 1'b1; tick_period = 16'd2; cmd_seq = 1'b0; cmd_delay = 1'b0;
        #3;
        check("por_en_out", en_out, 0);
        check("por_busy", busy, 0);
        check("por_delay_value", delay_value, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Random delay, P=2, start first sampled at edge 3.
        step(); step();
        cmd_delay = 1'b1;
        step();
        check("t4_delay_value", delay_value, 4);
        check("t4_busy", busy, 1);
        to_edge = -1;
        for (int i = 0; i < 40 && to_edge < 0; i++) begin
            step();
            if (time_out) to_edge = edge_no;
        end
        check("t4_timeout_cycle", to_edge, 11);
        step();
        check("t4_busy_after", busy, 0);

        // Re-trigger during COUNT is ignored.
        cmd_delay = 1'b0;
        step();
        cmd_delay = 1'b1;
        step();
        dv_cap = m_dv;
        to_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            cmd_delay = 1'b0;
            step();
            if (time_out) to_cnt++;
            if (m_busy) cmd_delay = 1'b1;
            step();
            if (time_out) to_cnt++;
        end
        for (int i = 0; i < 300 && m_busy; i++) begin
            step();
            if (time_out) to_cnt++;
        end
        for (int i = 0; i < 5; i++) begin
            step();
            if (time_out) to_cnt++;
        end
        check("t5_timeout_count", to_cnt, 1);
        check("t5_delay_value", delay_value, dv_cap);

        // Step pulses, P=4, 20 cycles, then cmd_seq dropped.
        cmd_delay = 1'b0; tick_period = 16'd4;
        apply_reset();
        cmd_seq = 1'b1;
        en_q.delete();
        for (int k = 1; k <= 20; k++) begin
            step();
            if (en_out) en_q.push_back(k);
        end
        check("t2_pulse_count", en_q.size(), 5);
        for (int i = 0; i < en_q.size() && i < 5; i++) check("t2_pulse_cycle", en_q[i], 4 * (i + 1));
        cmd_seq = 1'b0;
        en_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (en_out) en_cnt++;
        end
        check("t2_after_drop", en_cnt, 0);

        // P=0 behaves as 1: a pulse every cycle.
        tick_period = 16'd0;
        cmd_seq = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("t3_en_every_cycle", en_out, 1);
        end

        // Overlap, P=3: start at edge 3 (D=4), cmd_seq joins at edge 5.
        cmd_seq = 1'b0; tick_period = 16'd3;
        apply_reset();
        step(); step();
        cmd_delay = 1'b1;
        step();
        step();
        cmd_seq = 1'b1;
        en_q.delete();
        to_edge = -1; to_with_en = 0;
        for (int i = 0; i < 60 && to_edge < 0; i++) begin
            step();
            if (en_out) en_q.push_back(edge_no);
            if (time_out) begin
                to_edge = edge_no; to_with_en = en_out;
            end
        end
        check("t6_timeout_cycle", to_edge, 15);
        check("t6_en_with_timeout", to_with_en, 1);
        for (int i = 1; i < en_q.size(); i++) check("t6_en_period", en_q[i] - en_q[i-1], 3);

        // Async reset during COUNT with cmd_seq high: no time_out afterwards.
        cmd_delay = 1'b0;
        step();
        cmd_delay = 1'b1;
        step();
        check("t6_busy_before_rst", busy, 1);
        cmd_delay = 1'b0;
        apply_reset();
        lfsr_exp = '{1, 2, 4, 8};
        check("t1_lfsr0", dut.u_lfsr.value, lfsr_exp[0]);
        for (int i = 1; i < 4; i++) begin
            step();
            check("t1_lfsr", dut.u_lfsr.value, lfsr_exp[i]);
        end
        to_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (time_out) to_cnt++;
        end
        check("t6_no_timeout_after_rst", to_cnt, 0);

        // Randomized run against the model.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 199) == 0) tick_period = 16'($urandom_range(0, 4));
            if ($urandom_range(0, 49) == 0)  cmd_seq = ~cmd_seq;
            if ($urandom_range(0, 9) == 0)   cmd_delay = ~cmd_delay;
            if ($urandom_range(0, 1999) == 0) apply_reset();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
